mini_dpll_ctrl: RTL and testbench
=================================

Name: mini_dpll_ctrl

Overview:
- Parametrised DPLL decision/backtrack controller for the Mini solver family; drives an external propagation engine (PSE) over a start/done plus undo handshake and owns the decision stack.
- Generalises the first-generation core: configurable depth and widths, selectable decision polarity (neg-first, pos-first, phase-saving), conflict budget with UNKNOWN result, external abort, and correct multi-level chronological backtracking.

Parameters:
- MAX_VARS, 256, variable capacity; also the decision-stack depth.
- VAR_W, 9, bits for a variable index; must satisfy 2^VAR_W > MAX_VARS.
- TRAIL_W, 16, width of the PSE trail height.
- CNT_W, 32, width of the statistics and budget counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a solve from IDLE
- abort  in  1  forces result UNKNOWN from any busy state
- polarity_mode  in  2  0 = neg-first, 1 = pos-first, 2 = phase-saving, 3 = reserved (treated as 0)
- conflict_limit  in  CNT_W  0 = unlimited; sampled on start
- num_vars  in  VAR_W  active variable count; sampled on start
- assigned_mask  in  MAX_VARS  bit v-1 set when variable v is assigned (from PSE)
- pse_start  out  1  one-cycle pulse to the PSE
- pse_lit  out  VAR_W+1 signed  decision literal (0 = propagate only)
- pse_done  in  1  PSE finished propagating
- pse_conflict  in  1  valid when pse_done is high
- pse_undo_en  out  1  PSE pops its trail while this is high
- pse_undo_height  out  TRAIL_W  target trail height for the undo
- pse_trail_height  in  TRAIL_W  current PSE trail height
- busy  out  1  high whenever state is not IDLE or DONE
- done  out  1  level signal; held high in DONE
- result  out  2  0 = none, 1 = SAT, 2 = UNSAT, 3 = UNKNOWN
- conflict_count, decision_count  out  CNT_W  statistics
- level  out  VAR_W  current decision level

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE; every output, counter and stack entry is 0; the phase-save bits are 0 (negative).
- States:
  - IDLE: on start, clear counters and level, latch the budget and num_vars, pulse pse_start with lit 0, go to PROP.
  - PROP: wait for pse_done. If pse_conflict, conflict_count++ and go to ANALYZE. Else if no unassigned variable in 1..num_vars, go to DONE with SAT. Else go to DECIDE.
  - DECIDE: pick the lowest-index unassigned v (priority encoder over the assigned_mask bits masked to num_vars). Choose polarity per polarity_mode; phase-saving uses the saved phase of v. Push {v, first polarity, flipped = 0, trail_lim = pse_trail_height}. Increment level and decision_count, pulse pse_start with ±v, go to PROP.
  - ANALYZE:
    - If the budget is nonzero and conflict_count >= budget: go to DONE with UNKNOWN.
    - If level == 0: go to DONE with UNSAT.
    - If the top entry is not flipped: target = its trail_lim, go to UNDO with resume = 1.
    - Otherwise pop (level--). If the new level is 0, go to DONE with UNSAT; else stay in ANALYZE. Each evaluation costs 1 cycle.
  - UNDO: hold pse_undo_en with pse_undo_height = target until pse_trail_height <= target, then go to RESUME.
  - RESUME: set flipped = 1, record the new polarity as the phase of v, pulse pse_start with the opposite literal, go to PROP. The decision count is not incremented.
  - DONE: done = 1, result held. A new start returns to IDLE behaviour in the same cycle, acting as a restart.
- Phase-saving: the phase bit for v is written on every DECIDE and every RESUME. It survives across solves and is cleared only by reset.
- abort: takes priority over every transition. The next state is DONE with UNKNOWN; pse_undo_en and pse_start are low in the abort cycle.
- Simultaneous start and abort in IDLE: abort wins.
- pse_done arriving outside PROP is ignored.
- Counters saturate at all-ones.
- A push at level == MAX_VARS cannot occur when num_vars <= MAX_VARS. num_vars > MAX_VARS is clamped to MAX_VARS.
- Latency: the first pse_start is issued in the same cycle start is seen. Decision-to-pse_start is 1 cycle after PROP completes.

Decomposition:
- mini_pkg gains mini_dpll_state_t, the result encoding constants (RES_NONE/SAT/UNSAT/UNKNOWN) and the polarity mode constants.
- One sub-module is natural: mini_first_unassigned, a parametrised priority encoder from mask and limit to {found, index}.
- The stack stays inline as register arrays.

Test Plan:
- Two variables, no clauses (PSE model never conflicts), mode 0 -> decisions -1 then -2, SAT, decision_count = 2, conflict_count = 0.
- Mode 1, same setup -> literals +1 then +2 issued on pse_lit.
- Model conflicts whenever var1 = F and var2 = F -> sequence -1, -2, conflict, undo to trail_lim[1], +2, SAT; conflict_count = 1, decision_count = 2.
- Model conflicts on every leaf of 2 vars -> two-level pop exercised, UNSAT, conflict_count = 4.
- Same as the previous scenario with conflict_limit = 2 -> UNKNOWN after the 2nd conflict, level = 2.
- Assert abort mid-UNDO -> next cycle done = 1, result = 3, pse_undo_en = 0. Then phase-saving: re-solve in mode 2 reuses the last phases (+1 seen first).

Source files
------------

// File: rtl/mini_dpll_ctrl_pkg.sv
// Shared types and encodings for the Mini DPLL decision/backtrack controller.
package mini_dpll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROP,
        ST_DECIDE,
        ST_ANALYZE,
        ST_UNDO,
        ST_RESUME,
        ST_DONE
    } mini_dpll_state_t;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_SAT     = 2'd1;
    localparam logic [1:0] RES_UNSAT   = 2'd2;
    localparam logic [1:0] RES_UNKNOWN = 2'd3;

    localparam logic [1:0] POL_NEG_FIRST  = 2'd0;
    localparam logic [1:0] POL_POS_FIRST  = 2'd1;
    localparam logic [1:0] POL_PHASE_SAVE = 2'd2;
    localparam logic [1:0] POL_RESERVED   = 2'd3;

    // Returns 1 for a positive first literal.
    function automatic logic pick_polarity(input logic [1:0] mode, input logic saved);
        logic pol;
        case (mode)
            POL_POS_FIRST:               pol = 1'b1;
            POL_PHASE_SAVE:              pol = saved;
            POL_NEG_FIRST, POL_RESERVED: pol = 1'b0;
            default:                     pol = 1'b0;
        endcase
        return pol;
    endfunction

endpackage

// File: rtl/mini_dpll_ctrl_if.sv
// Controller <-> propagation engine (PSE) handshake, undo channel and assignment view.
interface mini_dpll_ctrl_if #(
    parameter int MAX_VARS = 256,
    parameter int VAR_W    = 9,
    parameter int TRAIL_W  = 16
);
    logic                  pse_start;
    logic signed [VAR_W:0] pse_lit;
    logic                  pse_done;
    logic                  pse_conflict;
    logic                  pse_undo_en;
    logic [TRAIL_W-1:0]    pse_undo_height;
    logic [TRAIL_W-1:0]    pse_trail_height;
    logic [MAX_VARS-1:0]   assigned_mask;

    modport master (
        output pse_start, pse_lit, pse_undo_en, pse_undo_height,
        input  pse_done, pse_conflict, pse_trail_height, assigned_mask
    );

    modport slave (
        input  pse_start, pse_lit, pse_undo_en, pse_undo_height,
        output pse_done, pse_conflict, pse_trail_height, assigned_mask
    );
endinterface

// File: rtl/mini_dpll_ctrl_first_unassigned.sv
// Priority encoder: lowest bit index below i_limit whose mask bit is clear.
module mini_dpll_ctrl_first_unassigned #(
    parameter int MAX_VARS = 256,
    parameter int VAR_W    = 9,
    parameter int IDX_W    = 8
) (
    input  logic [MAX_VARS-1:0] i_mask,
    input  logic [VAR_W-1:0]    i_limit,
    output logic                o_found,
    output logic [IDX_W-1:0]    o_index
);
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = MAX_VARS - 1; i >= 0; i--) begin
            if (!i_mask[i] && (VAR_W'(i) < i_limit)) begin
                o_found = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/mini_dpll_ctrl.sv
// DPLL decision/backtrack controller: owns the decision stack and drives the PSE.
// state   | meaning
// IDLE    | waiting for start
// PROP    | PSE propagating, waiting for pse_done
// DECIDE  | push lowest unassigned variable, issue its literal
// ANALYZE | conflict: budget check, pop flipped levels, pick undo target
// UNDO    | PSE pops its trail down to the target height
// RESUME  | flip top decision and issue the opposite literal
// DONE    | result held until the next start
module mini_dpll_ctrl
    import mini_dpll_ctrl_pkg::*;
#(
    parameter int MAX_VARS = 256,
    parameter int VAR_W    = 9,
    parameter int TRAIL_W  = 16,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [1:0]              i_polarity_mode,
    input  logic [CNT_W-1:0]        i_conflict_limit,
    input  logic [VAR_W-1:0]        i_num_vars,
    mini_dpll_ctrl_if.master        pse,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [1:0]              o_result,
    output logic [CNT_W-1:0]        o_conflict_count,
    output logic [CNT_W-1:0]        o_decision_count,
    output logic [VAR_W-1:0]        o_level
);
    localparam int IDX_W = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1;
    localparam logic [VAR_W-1:0] MAX_LVL = VAR_W'(MAX_VARS);
    localparam logic [VAR_W-1:0] LVL_ONE = VAR_W'(1);

    mini_dpll_state_t      r_state;
    logic [VAR_W-1:0]      r_level;
    logic [VAR_W-1:0]      r_num_vars;
    logic [CNT_W-1:0]      r_conf_cnt;
    logic [CNT_W-1:0]      r_dec_cnt;
    logic [CNT_W-1:0]      r_budget;
    logic [IDX_W-1:0]      r_stk_var [MAX_VARS];
    logic [TRAIL_W-1:0]    r_stk_lim [MAX_VARS];
    logic [MAX_VARS-1:0]   r_stk_pol;
    logic [MAX_VARS-1:0]   r_stk_flip;
    logic [MAX_VARS-1:0]   r_phase;
    logic                  r_pse_start;
    logic signed [VAR_W:0] r_pse_lit;
    logic                  r_undo_en;
    logic [TRAIL_W-1:0]    r_undo_height;
    logic [1:0]            r_result;

    logic                  w_found;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_top;
    logic [IDX_W-1:0]      w_push;
    logic                  w_first_pol;
    logic                  w_flip_pol;
    logic                  w_busy;
    logic                  w_budget_hit;
    logic [VAR_W-1:0]      w_nv_clamped;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic signed [VAR_W:0] make_lit(input logic [IDX_W-1:0] idx, input logic pos);
        logic signed [VAR_W:0] mag;
        mag = $signed({1'b0, VAR_W'(idx) + VAR_W'(1)});
        return pos ? mag : -mag;
    endfunction

    mini_dpll_ctrl_first_unassigned #(
        .MAX_VARS (MAX_VARS),
        .VAR_W    (VAR_W),
        .IDX_W    (IDX_W)
    ) u_first_unassigned (
        .i_mask  (pse.assigned_mask),
        .i_limit (r_num_vars),
        .o_found (w_found),
        .o_index (w_idx)
    );

    // Level L lives at stack slot L-1.
    assign w_top        = IDX_W'(r_level - LVL_ONE);
    assign w_push       = IDX_W'(r_level);
    assign w_first_pol  = pick_polarity(i_polarity_mode, r_phase[w_idx]);
    assign w_flip_pol   = ~r_stk_pol[w_top];
    assign w_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_budget_hit = (r_budget != '0) && (r_conf_cnt >= r_budget);
    assign w_nv_clamped = (i_num_vars > MAX_LVL) ? MAX_LVL : i_num_vars;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_level       <= '0;
            r_num_vars    <= '0;
            r_conf_cnt    <= '0;
            r_dec_cnt     <= '0;
            r_budget      <= '0;
            r_stk_pol     <= '0;
            r_stk_flip    <= '0;
            r_phase       <= '0;
            r_pse_start   <= 1'b0;
            r_pse_lit     <= '0;
            r_undo_en     <= 1'b0;
            r_undo_height <= '0;
            r_result      <= RES_NONE;
            for (int k = 0; k < MAX_VARS; k++) begin
                r_stk_var[k] <= '0;
                r_stk_lim[k] <= '0;
            end
        end else begin
            r_pse_start <= 1'b0;
            if (i_abort && (w_busy || i_start)) begin
                r_state   <= ST_DONE;
                r_result  <= RES_UNKNOWN;
                r_undo_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            r_conf_cnt  <= '0;
                            r_dec_cnt   <= '0;
                            r_level     <= '0;
                            r_budget    <= i_conflict_limit;
                            r_num_vars  <= w_nv_clamped;
                            r_result    <= RES_NONE;
                            r_pse_lit   <= '0;
                            r_pse_start <= 1'b1;
                            r_state     <= ST_PROP;
                        end
                    end
                    ST_PROP: begin
                        if (pse.pse_done) begin
                            if (pse.pse_conflict) begin
                                r_conf_cnt <= sat_inc(r_conf_cnt);
                                r_state    <= ST_ANALYZE;
                            end else if (!w_found) begin
                                r_result <= RES_SAT;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state <= ST_DECIDE;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        if (w_found) begin
                            r_stk_var[w_push]  <= w_idx;
                            r_stk_pol[w_push]  <= w_first_pol;
                            r_stk_flip[w_push] <= 1'b0;
                            r_stk_lim[w_push]  <= pse.pse_trail_height;
                            r_phase[w_idx]     <= w_first_pol;
                            r_level            <= r_level + LVL_ONE;
                            r_dec_cnt          <= sat_inc(r_dec_cnt);
                            r_pse_lit          <= make_lit(w_idx, w_first_pol);
                            r_pse_start        <= 1'b1;
                            r_state            <= ST_PROP;
                        end else begin
                            r_result <= RES_SAT;
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_ANALYZE: begin
                        if (w_budget_hit) begin
                            r_result <= RES_UNKNOWN;
                            r_state  <= ST_DONE;
                        end else if (r_level == '0) begin
                            r_result <= RES_UNSAT;
                            r_state  <= ST_DONE;
                        end else if (!r_stk_flip[w_top]) begin
                            r_undo_height <= r_stk_lim[w_top];
                            r_undo_en     <= 1'b1;
                            r_state       <= ST_UNDO;
                        end else begin
                            // Both branches of this level failed: pop one level per cycle.
                            r_level <= r_level - LVL_ONE;
                            if (r_level == LVL_ONE) begin
                                r_result <= RES_UNSAT;
                                r_state  <= ST_DONE;
                            end
                        end
                    end
                    ST_UNDO: begin
                        if (pse.pse_trail_height <= r_undo_height) begin
                            r_undo_en <= 1'b0;
                            r_state   <= ST_RESUME;
                        end
                    end
                    ST_RESUME: begin
                        r_stk_flip[w_top]         <= 1'b1;
                        r_stk_pol[w_top]          <= w_flip_pol;
                        r_phase[r_stk_var[w_top]] <= w_flip_pol;
                        r_pse_lit                 <= make_lit(r_stk_var[w_top], w_flip_pol);
                        r_pse_start               <= 1'b1;
                        r_state                   <= ST_PROP;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pse.pse_start       = r_pse_start;
    assign pse.pse_lit         = r_pse_lit;
    assign pse.pse_undo_en     = r_undo_en;
    assign pse.pse_undo_height = r_undo_height;

    assign o_busy           = w_busy;
    assign o_done           = (r_state == ST_DONE);
    assign o_result         = r_result;
    assign o_conflict_count = r_conf_cnt;
    assign o_decision_count = r_dec_cnt;
    assign o_level          = r_level;
endmodule

// File: tb/tb_mini_dpll_ctrl.sv
// Bench for mini_dpll_ctrl: two-variable PSE model with a literal/undo-height scoreboard.
module tb_mini_dpll_ctrl;
    import mini_dpll_ctrl_pkg::*;

    localparam int MAX_VARS = 256;
    localparam int VAR_W    = 9;
    localparam int TRAIL_W  = 16;
    localparam int CNT_W    = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic               i_abort;
    logic [1:0]         i_polarity_mode;
    logic [CNT_W-1:0]   i_conflict_limit;
    logic [VAR_W-1:0]   i_num_vars;
    logic               o_busy;
    logic               o_done;
    logic [1:0]         o_result;
    logic [CNT_W-1:0]   o_conflict_count;
    logic [CNT_W-1:0]   o_decision_count;
    logic [VAR_W-1:0]   o_level;

    mini_dpll_ctrl_if #(.MAX_VARS(MAX_VARS), .VAR_W(VAR_W), .TRAIL_W(TRAIL_W)) pse_if ();

    mini_dpll_ctrl #(
        .MAX_VARS (MAX_VARS),
        .VAR_W    (VAR_W),
        .TRAIL_W  (TRAIL_W),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_polarity_mode  (i_polarity_mode),
        .i_conflict_limit (i_conflict_limit),
        .i_num_vars       (i_num_vars),
        .pse              (pse_if),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_result         (o_result),
        .o_conflict_count (o_conflict_count),
        .o_decision_count (o_decision_count),
        .o_level          (o_level)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_lits [$];
    int  exp_undo [$];

    bit  m_asg [0:3];
    bit  m_val [0:3];
    int  m_trail [$];
    bit  m_pend;
    bit  m_undo_prev;
    int  m_undo_rises;
    int  m_kind;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // kind 0: never conflicts; 1: conflict on var1=F,var2=F; 2: conflict on every full assignment
    function automatic bit conflict_now();
        case (m_kind)
            1:       return m_asg[1] && m_asg[2] && !m_val[1] && !m_val[2];
            2:       return m_asg[1] && m_asg[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_pse_view();
        pse_if.assigned_mask    = '0;
        pse_if.assigned_mask[0] = m_asg[1];
        pse_if.assigned_mask[1] = m_asg[2];
        pse_if.pse_trail_height = TRAIL_W'(m_trail.size());
    endtask

    // One PSE model step, called just after each falling edge.
    task automatic pse_step();
        int lit;
        int v;
        pse_if.pse_done     = 1'b0;
        pse_if.pse_conflict = 1'b0;
        if (m_pend) begin
            pse_if.pse_done     = 1'b1;
            pse_if.pse_conflict = conflict_now();
            m_pend = 1'b0;
        end
        if (pse_if.pse_start) begin
            lit = pse_if.pse_lit;
            if (exp_lits.size() == 0) check_val("lit_unexpected", lit, 32'hDEAD_BEEF);
            else                      check_val("pse_lit", lit, exp_lits.pop_front());
            if (lit != 0) begin
                v = (lit < 0) ? -lit : lit;
                if (v >= 1 && v <= 2) begin
                    m_asg[v] = 1'b1;
                    m_val[v] = (lit > 0);
                    m_trail.push_back(v);
                end
            end
            m_pend = 1'b1;
        end
        if (pse_if.pse_undo_en) begin
            if (!m_undo_prev) begin
                m_undo_rises++;
                if (exp_undo.size() == 0) check_val("undo_unexpected", pse_if.pse_undo_height, 32'hDEAD_BEEF);
                else                      check_val("undo_height", pse_if.pse_undo_height, exp_undo.pop_front());
            end
            if (m_trail.size() > int'(pse_if.pse_undo_height)) begin
                v = m_trail.pop_back();
                m_asg[v] = 1'b0;
                m_val[v] = 1'b0;
            end
        end
        m_undo_prev = pse_if.pse_undo_en;
        drive_pse_view();
    endtask

    task automatic run_solve(input logic [1:0] mode, input int kind, input logic [31:0] limit,
                             input int abort_at, input string tag);
        bit finished;
        finished = 1'b0;
        m_kind = kind;
        for (int i = 0; i < 4; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
        m_trail.delete();
        m_pend       = 1'b0;
        m_undo_prev  = 1'b0;
        m_undo_rises = 0;
        pse_if.pse_done     = 1'b0;
        pse_if.pse_conflict = 1'b0;
        drive_pse_view();
        i_polarity_mode  = mode;
        i_conflict_limit = limit;
        i_num_vars       = VAR_W'(2);
        i_start          = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        pse_step();
        check_val({tag, "_busy"}, o_busy, 1);
        for (int c = 0; c < 400; c++) begin
            if (o_done) begin
                finished = 1'b1;
                break;
            end
            if (abort_at > 0 && pse_if.pse_undo_en && m_undo_rises == abort_at) begin
                i_abort = 1'b1;
                @(posedge clk);
                #1;
                check_val("abort_done",      o_done,             1);
                check_val("abort_result",    o_result,           RES_UNKNOWN);
                check_val("abort_undo_en",   pse_if.pse_undo_en, 0);
                check_val("abort_pse_start", pse_if.pse_start,   0);
                check_val("abort_busy",      o_busy,             0);
                @(negedge clk);
                i_abort  = 1'b0;
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            pse_step();
        end
        check_val({tag, "_finished"}, finished, 1);
        check_val({tag, "_lits_left"}, exp_lits.size(), 0);
        check_val({tag, "_undo_left"}, exp_undo.size(), 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_polarity_mode  = 2'd0;
        i_conflict_limit = '0;
        i_num_vars       = '0;
        pse_if.pse_done     = 1'b0;
        pse_if.pse_conflict = 1'b0;
        pse_if.assigned_mask    = '0;
        pse_if.pse_trail_height = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",      o_busy,             0);
        check_val("rst_done",      o_done,             0);
        check_val("rst_result",    o_result,           RES_NONE);
        check_val("rst_level",     o_level,            0);
        check_val("rst_conf",      o_conflict_count,   0);
        check_val("rst_dec",       o_decision_count,   0);
        check_val("rst_pse_start", pse_if.pse_start,   0);
        check_val("rst_pse_lit",   pse_if.pse_lit,     0);
        check_val("rst_undo_en",   pse_if.pse_undo_en, 0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_lits = '{0, -1, -2};
        run_solve(2'd0, 0, 0, 0, "neg_sat");
        check_val("neg_sat_result", o_result,         RES_SAT);
        check_val("neg_sat_dec",    o_decision_count, 2);
        check_val("neg_sat_conf",   o_conflict_count, 0);
        check_val("neg_sat_level",  o_level,          2);

        exp_lits = '{0, 1, 2};
        run_solve(2'd1, 0, 0, 0, "pos_sat");
        check_val("pos_sat_result", o_result,         RES_SAT);
        check_val("pos_sat_dec",    o_decision_count, 2);

        exp_lits = '{0, -1, -2};
        run_solve(2'd3, 0, 0, 0, "rsv_sat");
        check_val("rsv_sat_result", o_result, RES_SAT);

        exp_lits = '{0, -1, -2, 2};
        exp_undo = '{1};
        run_solve(2'd0, 1, 0, 0, "one_conf");
        check_val("one_conf_result", o_result,         RES_SAT);
        check_val("one_conf_conf",   o_conflict_count, 1);
        check_val("one_conf_dec",    o_decision_count, 2);
        check_val("one_conf_level",  o_level,          2);

        exp_lits = '{0, -1, -2, 2, 1, -2, 2};
        exp_undo = '{1, 0, 1};
        run_solve(2'd0, 2, 0, 0, "unsat");
        check_val("unsat_result", o_result,         RES_UNSAT);
        check_val("unsat_conf",   o_conflict_count, 4);
        check_val("unsat_dec",    o_decision_count, 3);
        check_val("unsat_level",  o_level,          0);

        exp_lits = '{0, -1, -2, 2};
        exp_undo = '{1};
        run_solve(2'd0, 2, 32'd2, 0, "budget");
        check_val("budget_result", o_result,         RES_UNKNOWN);
        check_val("budget_conf",   o_conflict_count, 2);
        check_val("budget_level",  o_level,          2);

        exp_lits = '{0, -1, -2, 2, 1, -2};
        exp_undo = '{1, 0, 1};
        run_solve(2'd0, 2, 0, 3, "abort");
        check_val("abort_conf", o_conflict_count, 3);
        check_val("abort_dec",  o_decision_count, 3);

        exp_lits = '{0, 1, -2};
        run_solve(2'd2, 0, 0, 0, "phase");
        check_val("phase_result", o_result,         RES_SAT);
        check_val("phase_dec",    o_decision_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
